// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the npc core.
// Owns the architectural PC and issues one 32-bit fetch at a time over a
// valid/ready request channel. Each instruction goes to the decoder through a
// valid/ready handshake. Redirects from execute re-steer the PC, and any
// response that is still in flight is dropped.
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(64'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction memory request / response
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [31:0]           imem_resp_data,
    // decoder handshake
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    // control-flow redirect from execute
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    // status
    output logic                  fetch_fault,
    output logic [63:0]           fetch_count
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // request presented at pc
        S_WAIT  = 2'd1,  // request accepted, waiting for the response
        S_HOLD  = 2'd2,  // instruction offered to the decoder
        S_FAULT = 2'd3   // misaligned redirect seen, stopped until reset
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  drop_q, drop_d;
    logic [31:0]           inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [63:0]           fetch_count_q, fetch_count_d;

    logic redirect_ok;
    logic redirect_bad;

    assign redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // State and datapath registers, with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            inst_q        <= 32'd0;
            inst_pc_q     <= RESET_PC;
            fetch_count_q <= 64'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state, PC, drop flag, held instruction and handshake counter.
    always_comb begin
        // NOTE: every signal gets a hold default first, so no path leaves a latch behind.
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            S_REQ: begin
                if (redirect_bad) begin
                    state_d = S_FAULT;
                end else begin
                    if (redirect_ok) begin
                        pc_d = redirect_pc;
                    end
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                        // The accepted request used the old pc, so its response is stale.
                        drop_d  = redirect_ok;
                    end
                end
            end

            S_WAIT: begin
                if (redirect_bad) begin
                    state_d = S_FAULT;
                end else if (redirect_ok) begin
                    pc_d = redirect_pc;
                    if (imem_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = imem_resp_data;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // A decoder handshake in this cycle counts even if a redirect squashes the stream.
                if (inst_ready) begin
                    fetch_count_d = fetch_count_q + 64'd1;
                end
                if (redirect_bad) begin
                    state_d = S_FAULT;
                end else if (redirect_ok) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                    state_d = S_REQ;
                end
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Outputs are decoded from registers only; rst forces the idle values.
    always_comb begin
        imem_req_valid = !rst && (state_q == S_REQ);
        imem_req_addr  = pc_q;
        inst_valid     = !rst && (state_q == S_HOLD);
        inst           = rst ? 32'd0 : inst_q;
        inst_pc        = rst ? RESET_PC : inst_pc_q;
        fetch_fault    = !rst && (state_q == S_FAULT);
        fetch_count    = fetch_count_q;
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed, table-driven bench for ifu_fetch.
// Each table row is one clock cycle. It gives the inputs to drive and the
// outputs expected in that cycle, before the next rising edge. A short
// hand-written loop then checks back-to-back throughput against a 1-cycle memory.
module tb_ifu_fetch;

    localparam logic [63:0] A = 64'h8000_0000;
    localparam logic [63:0] X = 64'd0;  // don't-care address for rows where no request is expected

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_fault;
    logic [63:0] fetch_count;

    ifu_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fetch_fault     (fetch_fault),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rsp;
        logic [31:0] rdata;
        logic        irdy;
        logic        rdr;
        logic [63:0] rpc;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [63:0] e_ipc;
        logic        e_flt;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   n_miss    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic rdy, input logic rsp, input logic [31:0] rdata,
                     input logic irdy, input logic rdr, input logic [63:0] rpc,
                     input logic e_rv, input logic [63:0] e_addr, input logic e_iv,
                     input logic [31:0] e_inst, input logic [63:0] e_ipc,
                     input logic e_flt, input logic [63:0] e_cnt);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.rsp = rsp; t.rdata = rdata; t.irdy = irdy;
        t.rdr = rdr; t.rpc = rpc; t.e_rv = e_rv; t.e_addr = e_addr; t.e_iv = e_iv;
        t.e_inst = e_inst; t.e_ipc = e_ipc; t.e_flt = e_flt; t.e_cnt = e_cnt;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rsp, input logic [31:0] rdata,
                         input logic irdy, input logic rdr, input logic [63:0] rpc);
        rst             = r;
        imem_req_ready  = rdy;
        imem_resp_valid = rsp;
        imem_resp_data  = rdata;
        inst_ready      = irdy;
        redirect_valid  = rdr;
        redirect_pc     = rpc;
    endtask

    initial begin
        int  iv_seen;
        logic acc_prev;

        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        repeat (2) @(posedge clk);

        //  rst rdy rsp rdata         irdy rdr rpc                      | rv addr          iv inst          inst_pc          flt cnt
        v(1, 0, 0, 32'h0,          0, 0, X,                     0, X,             0, 32'h0,        A,              0, 0);
        // back-to-back fetch, 1-cycle memory
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, A,             0, 32'h0,        A,              0, 0);
        v(0, 0, 1, 32'h13,         0, 0, X,                     0, X,             0, 32'h0,        A,              0, 0);
        v(0, 0, 0, 32'h0,          1, 0, X,                     0, X,             1, 32'h13,       A,              0, 0);
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, A+4,           0, 32'h13,       A,              0, 1);
        v(0, 0, 1, 32'h13,         0, 0, X,                     0, X,             0, 32'h13,       A,              0, 1);
        v(0, 0, 0, 32'h0,          1, 0, X,                     0, X,             1, 32'h13,       A+4,            0, 1);
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, A+8,           0, 32'h13,       A+4,            0, 2);
        v(0, 0, 1, 32'h13,         0, 0, X,                     0, X,             0, 32'h13,       A+4,            0, 2);
        v(0, 0, 0, 32'h0,          1, 0, X,                     0, X,             1, 32'h13,       A+8,            0, 2);
        v(0, 0, 0, 32'h0,          0, 0, X,                     1, A+12,          0, 32'h13,       A+8,            0, 3);
        // decoder backpressure for 5 cycles
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, A+12,          0, 32'h13,       A+8,            0, 3);
        v(0, 0, 1, 32'h0010_0093,  0, 0, X,                     0, X,             0, 32'h13,       A+8,            0, 3);
        for (int k = 0; k < 5; k++)
            v(0, 0, 0, 32'h0,      0, 0, X,                     0, X,             1, 32'h0010_0093, A+12,          0, 3);
        v(0, 0, 0, 32'h0,          1, 0, X,                     0, X,             1, 32'h0010_0093, A+12,          0, 3);
        v(0, 0, 0, 32'h0,          0, 0, X,                     1, A+16,          0, 32'h0010_0093, A+12,          0, 4);
        // redirect in WAIT, response two cycles later is dropped
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, A+16,          0, 32'h0010_0093, A+12,          0, 4);
        v(0, 0, 0, 32'h0,          0, 1, A+64'h100,             0, X,             0, 32'h0010_0093, A+12,          0, 4);
        v(0, 0, 0, 32'h0,          0, 0, X,                     0, X,             0, 32'h0010_0093, A+12,          0, 4);
        v(0, 0, 1, 32'hDEAD_BEEF,  0, 0, X,                     0, X,             0, 32'h0010_0093, A+12,          0, 4);
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, A+64'h100,     0, 32'h0010_0093, A+12,          0, 4);
        v(0, 0, 1, 32'h0000_0517,  0, 0, X,                     0, X,             0, 32'h0010_0093, A+12,          0, 4);
        // redirect in HOLD together with inst_ready
        v(0, 0, 0, 32'h0,          1, 1, A+64'h200,             0, X,             1, 32'h0000_0517, A+64'h100,     0, 4);
        // memory stalls the request for 4 cycles
        for (int k = 0; k < 4; k++)
            v(0, 0, 0, 32'h0,      0, 0, X,                     1, A+64'h200,     0, 32'h0000_0517, A+64'h100,     0, 5);
        // redirect in REQ, not accepted: address changes the following cycle
        v(0, 0, 0, 32'h0,          0, 1, A+64'h300,             1, A+64'h200,     0, 32'h0000_0517, A+64'h100,     0, 5);
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, A+64'h300,     0, 32'h0000_0517, A+64'h100,     0, 5);
        v(0, 0, 1, 32'h13,         0, 0, X,                     0, X,             0, 32'h0000_0517, A+64'h100,     0, 5);
        v(0, 0, 0, 32'h0,          1, 0, X,                     0, X,             1, 32'h13,       A+64'h300,      0, 5);
        // redirect in REQ, accepted same cycle: stale response dropped
        v(0, 1, 0, 32'h0,          0, 1, A+64'h400,             1, A+64'h304,     0, 32'h13,       A+64'h300,      0, 6);
        v(0, 0, 1, 32'hBAD0_0001,  0, 0, X,                     0, X,             0, 32'h13,       A+64'h300,      0, 6);
        v(0, 0, 0, 32'h0,          0, 0, X,                     1, A+64'h400,     0, 32'h13,       A+64'h300,      0, 6);
        // redirect in WAIT coincident with the response
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, A+64'h400,     0, 32'h13,       A+64'h300,      0, 6);
        v(0, 0, 1, 32'hBAD0_0002,  0, 1, A+64'h500,             0, X,             0, 32'h13,       A+64'h300,      0, 6);
        v(0, 0, 0, 32'h0,          0, 0, X,                     1, A+64'h500,     0, 32'h13,       A+64'h300,      0, 6);
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, A+64'h500,     0, 32'h13,       A+64'h300,      0, 6);
        v(0, 0, 1, 32'h00A0_0093,  0, 0, X,                     0, X,             0, 32'h13,       A+64'h300,      0, 6);
        v(0, 0, 0, 32'h0,          0, 0, X,                     0, X,             1, 32'h00A0_0093, A+64'h500,     0, 6);
        // misaligned redirect -> sticky fault, later redirects ignored
        v(0, 0, 0, 32'h0,          0, 1, A+64'h102,             0, X,             1, 32'h00A0_0093, A+64'h500,     0, 6);
        v(0, 1, 0, 32'h0,          0, 0, X,                     0, X,             0, 32'h00A0_0093, A+64'h500,     1, 6);
        v(0, 1, 0, 32'h0,          1, 1, A+64'h600,             0, X,             0, 32'h00A0_0093, A+64'h500,     1, 6);
        v(0, 1, 0, 32'h0,          1, 0, X,                     0, X,             0, 32'h00A0_0093, A+64'h500,     1, 6);
        // reset clears the fault and restarts at RESET_PC
        v(1, 0, 0, 32'h0,          0, 0, X,                     0, X,             0, 32'h0,        A,              0, 6);
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, A,             0, 32'h0,        A,              0, 0);
        // reset in WAIT, late response afterwards ignored
        v(1, 0, 0, 32'h0,          0, 0, X,                     0, X,             0, 32'h0,        A,              0, 0);
        v(0, 0, 1, 32'hBAD0_0003,  0, 0, X,                     1, A,             0, 32'h0,        A,              0, 0);
        v(0, 0, 0, 32'h0,          0, 0, X,                     1, A,             0, 32'h0,        A,              0, 0);
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, A,             0, 32'h0,        A,              0, 0);
        v(0, 0, 1, 32'h13,         0, 0, X,                     0, X,             0, 32'h0,        A,              0, 0);
        v(0, 0, 0, 32'h0,          1, 0, X,                     0, X,             1, 32'h13,       A,              0, 0);
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, A+4,           0, 32'h13,       A,              0, 1);
        // pc wraps modulo 2^64 (response together with a redirect is dropped)
        v(0, 0, 1, 32'h0,          0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, X,           0, 32'h13,       A,              0, 1);
        v(0, 1, 0, 32'h0,          0, 0, X,                     1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h13, A,         0, 1);
        v(0, 0, 1, 32'h13,         0, 0, X,                     0, X,             0, 32'h13,       A,              0, 1);
        v(0, 0, 0, 32'h0,          1, 0, X,                     0, X,             1, 32'h13,       64'hFFFF_FFFF_FFFF_FFFC, 0, 1);
        v(0, 0, 0, 32'h0,          0, 0, X,                     1, 64'h0,         0, 32'h13,       64'hFFFF_FFFF_FFFF_FFFC, 0, 2);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rsp, vecs[i].rdata,
                  vecs[i].irdy, vecs[i].rdr, vecs[i].rpc);
            #1;
            check($sformatf("v%0d req_valid", i), 64'(imem_req_valid), 64'(vecs[i].e_rv));
            if (vecs[i].e_rv)
                check($sformatf("v%0d req_addr", i), imem_req_addr, vecs[i].e_addr);
            check($sformatf("v%0d inst_valid", i), 64'(inst_valid), 64'(vecs[i].e_iv));
            check($sformatf("v%0d inst", i), 64'(inst), 64'(vecs[i].e_inst));
            check($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].e_ipc);
            check($sformatf("v%0d fetch_fault", i), 64'(fetch_fault), 64'(vecs[i].e_flt));
            check($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].e_cnt);
        end

        // Throughput: always-ready memory with 1-cycle latency, always-ready decoder.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        @(negedge clk);
        iv_seen  = 0;
        acc_prev = 1'b0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 1'b1, acc_prev, 32'h0000_0013, 1'b1, 1'b0, 64'd0);
            #1;
            if (c == 0)
                check("thru first_req_addr", imem_req_addr, A);
            if (inst_valid) begin
                iv_seen++;
                check($sformatf("thru inst_pc_%0d", iv_seen), inst_pc, A + 64'(4 * (iv_seen - 1)));
            end
            acc_prev = imem_req_valid && imem_req_ready;
            @(negedge clk);
        end
        check("thru inst_valid_cycles", 64'(iv_seen), 64'd4);
        check("thru fetch_count", fetch_count, 64'd4);
        check("thru next_addr", imem_req_addr, A + 64'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish within 20000 time units");
        $fatal(1);
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the npc core: owns the architectural PC, issues 32-bit instruction reads to instruction memory over a valid/ready request channel, and delivers each fetched instruction with its PC to the decoder through a valid/ready handshake. It sits directly upstream of the decoder. It replaces the combinational PC-to-memory path with a multi-cycle, stallable fetch that tolerates variable memory latency and control-flow redirects from execute (jal and later branches).

## Interface
- `ADDR_WIDTH`, default 64: PC and address width.
- `RESET_PC`, default 64'h8000_0000: PC loaded on reset.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  ADDR_WIDTH  fetch address, always 4-byte aligned.
- `imem_resp_valid`  in  1  response data valid (one-cycle pulse, no backpressure).
- `imem_resp_data`  in  32  fetched instruction word.
- `inst_valid`  out  1  instruction available to decoder.
- `inst_ready`  in  1  decoder consumes the instruction this cycle.
- `inst`  out  32  instruction word.
- `inst_pc`  out  ADDR_WIDTH  PC of `inst`.
- `redirect_valid`  in  1  control-flow redirect from execute.
- `redirect_pc`  in  ADDR_WIDTH  redirect target.
- `fetch_fault`  out  1  sticky misaligned-target fault.
- `fetch_count`  out  64  number of instructions handed to decoder.

## Operation
- States: REQ, WAIT, HOLD, FAULT. Reset: state=REQ, pc=RESET_PC, drop=0, fetch_count=0; while `rst` high all outputs `imem_req_valid`, `inst_valid`, `fetch_fault` are 0, `inst`=0, `inst_pc`=RESET_PC.
- REQ: `imem_req_valid`=1, `imem_req_addr`=pc. On `imem_req_ready` -> WAIT.
- WAIT: no request. On `imem_resp_valid`: if drop=1, discard data, clear drop, -> REQ; else latch `inst`=data, `inst_pc`=pc, -> HOLD.
- HOLD: `inst_valid`=1, `inst`/`inst_pc` stable. On `inst_ready`: pc <= pc+4 (modulo 2^ADDR_WIDTH), fetch_count +1, -> REQ.
- FAULT: no requests, `inst_valid`=0, `fetch_fault`=1 until `rst`.
- Redirect (`redirect_valid`=1) with `redirect_pc[1:0]`!=0: -> FAULT regardless of state; pc unchanged.
- Aligned redirect: pc <= `redirect_pc`, and per state:
  - REQ, not accepted this cycle: stay REQ; address switches to target next cycle (only permitted address change while valid).
  - REQ, accepted same cycle: -> WAIT with drop=1 (old-PC response discarded).
  - WAIT, no response this cycle: drop=1. Response in same cycle: response discarded, -> REQ.
  - HOLD: held instruction squashed, `inst_valid`=0 next cycle, -> REQ. If `inst_ready` same cycle, the handshake counts (fetch_count +1) but pc = `redirect_pc`, not pc+4.
- Redirect in FAULT ignored. `imem_resp_valid` in REQ or HOLD is a protocol error; ignore it.
- fetch_count wraps at 2^64.

## Timing
- All outputs registered or decoded from state/pc registers; no combinational path from `inst_ready`, `redirect_valid` or `imem_*` inputs to any output.
- Request accepted cycle N; response no earlier than N+1; `inst_valid` first high the cycle after response. Best case: accept N, resp N+1, inst_valid N+2, consume N+2, next request N+3 → one instruction per 3 cycles.
- First request: `imem_req_valid`=1 in the first cycle after `rst` falls, addr=RESET_PC.
- Reset mid-operation overrides everything next edge; an outstanding response arriving after reset is ignored (state REQ).

## Test plan
- Reset, memory ready=1, 1-cycle latency returning 32'h0000_0013 -> req addrs 8000_0000, 8000_0004, 8000_0008; `inst_valid` every 3rd cycle; fetch_count=3 after three handshakes.
- Decoder holds `inst_ready`=0 for 5 cycles -> `inst`/`inst_pc` stable, no new request, fetch_count unchanged; release -> pc+4 request next cycle.
- Redirect to 8000_0100 while in WAIT, response arrives 2 cycles later -> response discarded, next request addr 8000_0100, delivered `inst_pc`=8000_0100.
- Redirect to 8000_0200 in HOLD coincident with `inst_ready` -> fetch_count +1, next request 8000_0200 (not pc+4).
- Redirect to 8000_0102 -> `fetch_fault`=1, no further requests or inst_valid; `rst` clears fault and restarts at 8000_0000.
- Memory stalls `imem_req_ready`=0 for 4 cycles -> `imem_req_valid` held high, address constant; assert `rst` in WAIT -> next request at RESET_PC, late response ignored.
